// File: rtl/pipe_addsub_n.sv
`default_nettype none
// ============================================================================
// Module   : pipe_addsub_n
// Purpose  : Pipelined WIDTH-bit adder/subtractor with a valid/ready stream.
//            The carry chain is cut into STAGES chunks of WIDTH/STAGES bits,
//            one register per chunk. Operand chunks not yet consumed travel
//            with the beat (skew), and finished low-order sum chunks travel
//            alongside until the last stage (deskew), so every bit of a beat
//            leaves in the same cycle.
// Ports    : clk, rst          rising-edge clock, synchronous active-high reset
//            in_valid/in_ready operand handshake
//            a, b, cin, sub    operands; sub=1 computes a-b-cin
//            out_valid/out_ready result handshake
//            sum, cout, ovf    result, carry out (sub: 1 = no borrow),
//                              signed overflow
// Options  : PIPE_ADDSUB_SAT_EN defined -> sum saturates to the signed limit
//            on overflow (cout/ovf still report the raw result).
// Revision : 1.0  initial release
// ============================================================================
module pipe_addsub_n #(
   parameter int WIDTH  = 16,
   parameter int STAGES = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);
   localparam int C = WIDTH / STAGES;

   logic [WIDTH-1:0] w_b_eff;
   logic             r_out_valid;
   logic [WIDTH-1:0] r_sum;
   logic             r_cout;
   logic             r_ovf;

   // Subtraction is a + ~b + ~cin, so both b and the carry-in are inverted.
   assign w_b_eff = sub ? ~b : b;

   // The whole pipe advances in lock-step; it only holds when the output
   // register is occupied and not being drained. Ready is also forced high
   // while in reset.
   assign in_ready  = rst | ~r_out_valid | out_ready;

   assign out_valid = r_out_valid;
   assign sum       = r_sum;
   assign cout      = r_cout;
   assign ovf       = r_ovf;

   genvar k;
   generate
      for (k = 0; k < STAGES; k++) begin : g_stage
         localparam int LO = k * C;        // lowest bit of this stage's chunk
         localparam int BW = WIDTH - LO;   // b' bits still outstanding here

         // w_x_in: sum bits below LO, operand-a bits from LO upward.
         logic [WIDTH-1:0] w_x_in;
         logic [WIDTH-1:0] w_x_out;
         // w_bh_in: remaining b' chunks, this stage's chunk at bit 0.
         logic [BW-1:0]    w_bh_in;
         logic             w_c_in;
         logic             w_v_in;
         logic [C:0]       w_chunk;

         if (k == 0) begin : g_first
            assign w_x_in  = a;
            assign w_bh_in = w_b_eff;
            assign w_c_in  = sub ^ cin;
            assign w_v_in  = in_valid;
         end else begin : g_inner
            assign w_x_in  = g_stage[k-1].g_mid.r_x;
            assign w_bh_in = g_stage[k-1].g_mid.r_bh;
            assign w_c_in  = g_stage[k-1].g_mid.r_c;
            assign w_v_in  = g_stage[k-1].g_mid.r_v;
         end

         assign w_chunk = {1'b0, w_x_in[LO +: C]}
                        + {1'b0, w_bh_in[C-1:0]}
                        + {{C{1'b0}}, w_c_in};

         // The finished chunk replaces the consumed a-chunk in place.
         always_comb begin
            w_x_out          = w_x_in;
            w_x_out[LO +: C] = w_chunk[C-1:0];
         end

         if (k < STAGES - 1) begin : g_mid
            logic [WIDTH-1:0]  r_x;
            logic [BW-C-1:0]   r_bh;
            logic              r_c;
            logic              r_v;

            // Only the valid bit is reset; data in invalid slots is
            // don't-care and is masked at the output register.
            always_ff @(posedge clk) begin
               if (rst) begin
                  r_v <= 1'b0;
               end else if (in_ready) begin
                  r_v <= w_v_in;
               end
               if (!rst && in_ready) begin
                  r_x  <= w_x_out;
                  r_bh <= w_bh_in[BW-1:C];
                  r_c  <= w_chunk[C];
               end
            end
         end else begin : g_last
            logic             w_ovf;
            logic [WIDTH-1:0] w_res;

            // Signed overflow: operands share a sign that the result lacks.
            // Equivalent to carry-into-MSB xor carry-out-of-MSB.
            assign w_ovf = (w_x_in[WIDTH-1] == w_bh_in[C-1])
                         & (w_x_out[WIDTH-1] != w_x_in[WIDTH-1]);

`ifdef PIPE_ADDSUB_SAT_EN
            // On overflow the operand sign gives the true result's sign.
            always_comb begin
               w_res = w_x_out;
               if (w_ovf) begin
                  w_res = w_x_in[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                          : {1'b0, {(WIDTH-1){1'b1}}};
               end
            end
`else
            assign w_res = w_x_out;
`endif

            // Invalid slots are written as zero so idle outputs read 0.
            always_ff @(posedge clk) begin
               if (rst) begin
                  r_out_valid <= 1'b0;
                  r_sum       <= '0;
                  r_cout      <= 1'b0;
                  r_ovf       <= 1'b0;
               end else if (in_ready) begin
                  r_out_valid <= w_v_in;
                  r_sum       <= w_v_in ? w_res : '0;
                  r_cout      <= w_v_in & w_chunk[C];
                  r_ovf       <= w_v_in & w_ovf;
               end
            end
         end
      end
   endgenerate

endmodule
`default_nettype wire

// File: tb/tb_pipe_addsub_n.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_pipe_addsub_n
// Purpose  : Self-checking bench for pipe_addsub_n. A WIDTH=16/STAGES=4
//            instance runs directed vectors, a stalled stream and a reset
//            flush; STAGES=1 and STAGES=16 instances run random beats
//            against an integer reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_pipe_addsub_n;
   localparam int W = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst, in_valid, cin, sub, out_ready;
   logic [W-1:0]  a, b;
   logic          in_ready, out_valid, cout, ovf;
   logic [W-1:0]  sum;

   logic          r_valid, r_cin, r_sub, r_ready;
   logic [W-1:0]  r_a, r_b;
   logic          s1_in_ready, s1_out_valid, s1_cout, s1_ovf;
   logic [W-1:0]  s1_sum;
   logic          s16_in_ready, s16_out_valid, s16_cout, s16_ovf;
   logic [W-1:0]  s16_sum;

   pipe_addsub_n #(.WIDTH(W), .STAGES(4)) u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
      .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf));

   pipe_addsub_n #(.WIDTH(W), .STAGES(1)) u_s1 (
      .clk(clk), .rst(rst), .in_valid(r_valid), .in_ready(s1_in_ready),
      .a(r_a), .b(r_b), .cin(r_cin), .sub(r_sub), .out_valid(s1_out_valid),
      .out_ready(r_ready), .sum(s1_sum), .cout(s1_cout), .ovf(s1_ovf));

   pipe_addsub_n #(.WIDTH(W), .STAGES(16)) u_s16 (
      .clk(clk), .rst(rst), .in_valid(r_valid), .in_ready(s16_in_ready),
      .a(r_a), .b(r_b), .cin(r_cin), .sub(r_sub), .out_valid(s16_out_valid),
      .out_ready(r_ready), .sum(s16_sum), .cout(s16_cout), .ovf(s16_ovf));

   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   // Reference built from integer arithmetic: true signed result decides
   // overflow/saturation, unsigned comparison decides carry/no-borrow.
   function automatic logic [18:0] model(input logic v, input logic [15:0] x,
                                         input logic [15:0] y, input logic ci,
                                         input logic s);
      int sx, sy, ux, uy, tr;
      logic c, o;
      logic [15:0] r;
      if (!v) return '0;
      sx = $signed(x);
      sy = $signed(y);
      ux = int'(x);
      uy = int'(y);
      if (s) begin
         tr = sx - sy - int'(ci);
         c  = (ux >= uy + int'(ci));
      end else begin
         tr = sx + sy + int'(ci);
         c  = (ux + uy + int'(ci)) > 65535;
      end
      o = (tr > 32767) || (tr < -32768);
      r = tr[15:0];
`ifdef PIPE_ADDSUB_SAT_EN
      if (tr > 32767)       r = 16'h7FFF;
      else if (tr < -32768) r = 16'h8000;
`endif
      return {1'b1, c, o, r};
   endfunction

   typedef struct {
      logic        sub;
      logic        cin;
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] s;
      logic [15:0] s_sat;
      logic        c;
      logic        o;
   } vec_t;

   localparam int NV = 10;
   vec_t vecs [NV];

   logic [18:0] q1[$];
   logic [18:0] q16[$];

   initial begin
      int lat, sent, got, leak;
      logic acc, stalled_prev;
      logic [15:0] held_sum, req_s;
      logic [18:0] e, exp1, exp16;

      //             sub  cin  a         b         sum       sum(sat)  c     o
      vecs[0] = '{1'b0, 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 1'b1, 1'b0};
      vecs[1] = '{1'b0, 1'b0, 16'h7FFF, 16'h0001, 16'h8000, 16'h7FFF, 1'b0, 1'b1};
      vecs[2] = '{1'b1, 1'b0, 16'h0005, 16'h0007, 16'hFFFE, 16'hFFFE, 1'b0, 1'b0};
      vecs[3] = '{1'b1, 1'b0, 16'h8000, 16'h0001, 16'h7FFF, 16'h8000, 1'b1, 1'b1};
      vecs[4] = '{1'b0, 1'b1, 16'h1234, 16'h4321, 16'h5556, 16'h5556, 1'b0, 1'b0};
      vecs[5] = '{1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0};
      vecs[6] = '{1'b1, 1'b1, 16'h0003, 16'h0001, 16'h0001, 16'h0001, 1'b1, 1'b0};
      vecs[7] = '{1'b0, 1'b0, 16'h8000, 16'h8000, 16'h0000, 16'h8000, 1'b1, 1'b1};
      vecs[8] = '{1'b0, 1'b0, 16'h00FF, 16'h0001, 16'h0100, 16'h0100, 1'b0, 1'b0};
      vecs[9] = '{1'b1, 1'b0, 16'h0000, 16'h0001, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0};

      rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
      out_ready = 1'b1;
      r_valid = 1'b0; r_a = '0; r_b = '0; r_cin = 1'b0; r_sub = 1'b0; r_ready = 1'b1;

      // ---------------- reset state ----------------
      repeat (2) @(posedge clk);
      #1;
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_sum", sum, 0);
      check("rst_cout", cout, 0);
      check("rst_ovf", ovf, 0);
      rst = 1'b0;
      @(posedge clk); #1;

      // ---------------- directed vectors, single beats ----------------
      for (int i = 0; i < NV; i++) begin
         a = vecs[i].a; b = vecs[i].b; cin = vecs[i].cin; sub = vecs[i].sub;
         in_valid = 1'b1;
         @(posedge clk); #1;
         in_valid = 1'b0;
         lat = 1;
         while (!out_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
         end
`ifdef PIPE_ADDSUB_SAT_EN
         req_s = vecs[i].s_sat;
`else
         req_s = vecs[i].s;
`endif
         check($sformatf("vec%0d_latency", i), lat, 4);
         check($sformatf("vec%0d_sum", i), sum, req_s);
         check($sformatf("vec%0d_cout", i), cout, vecs[i].c);
         check($sformatf("vec%0d_ovf", i), ovf, vecs[i].o);
         @(posedge clk); #1;
         check($sformatf("vec%0d_idle_zero", i), {out_valid, cout, ovf, sum}, 0);
      end

      // ---------------- back-to-back stream with a mid-stream stall ----------------
      sent = 0; got = 0; stalled_prev = 1'b0; held_sum = '0;
      for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
         in_valid  = (sent < 8);
         a         = sent[15:0];
         b         = sent[15:0];
         cin       = 1'b0;
         sub       = 1'b0;
         out_ready = !(cyc >= 6 && cyc < 9);
         #1;
         if (stalled_prev) begin
            check("stall_hold_valid", out_valid, 1);
            check("stall_hold_sum", sum, held_sum);
         end
         if (out_valid && !out_ready) begin
            check("stall_in_ready", in_ready, 0);
            held_sum     = sum;
            stalled_prev = 1'b1;
         end else begin
            stalled_prev = 1'b0;
         end
         if (out_valid && out_ready) begin
            check($sformatf("stream_beat%0d", got), sum, 2 * got);
            got++;
         end
         acc = in_valid && in_ready;
         @(posedge clk); #1;
         if (acc) sent++;
      end
      check("stream_count", got, 8);
      in_valid = 1'b0; out_ready = 1'b1;
      repeat (6) @(posedge clk);
      #1;

      // ---------------- reset with beats in flight ----------------
      for (int j = 0; j < 3; j++) begin
         in_valid = 1'b1; a = 16'h1000 + 16'(j); b = 16'h0001; cin = 1'b0; sub = 1'b0;
         @(posedge clk); #1;
      end
      rst = 1'b1; in_valid = 1'b1; a = 16'h7777; b = 16'h0000;
      @(posedge clk); #1;
      rst = 1'b0; in_valid = 1'b0;
      check("flush_out_valid", out_valid, 0);
      check("flush_sum", sum, 0);
      check("flush_in_ready", in_ready, 1);
      leak = 0;
      repeat (6) begin
         @(posedge clk); #1;
         if (out_valid) leak++;
      end
      check("flush_no_leak", leak, 0);
      in_valid = 1'b1; a = 16'h0101; b = 16'h0202; cin = 1'b0; sub = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 10) begin
         @(posedge clk); #1;
         lat++;
      end
      check("post_rst_latency", lat, 4);
      check("post_rst_sum", sum, 16'h0303);

      // ---------------- STAGES=1 / STAGES=16 random vs model ----------------
      for (int t = 0; t < 300; t++) begin
         r_valid = ($urandom_range(0, 3) != 0);
         r_a     = 16'($urandom);
         r_b     = 16'($urandom);
         r_cin   = 1'($urandom_range(0, 1));
         r_sub   = 1'($urandom_range(0, 1));
         e = model(r_valid, r_a, r_b, r_cin, r_sub);
         q1.push_back(e);
         q16.push_back(e);
         @(posedge clk); #1;
         if (q1.size() >= 1) begin
            exp1 = q1.pop_front();
            check("rand_s1", {s1_out_valid, s1_cout, s1_ovf, s1_sum}, exp1);
         end
         if (q16.size() >= 16) begin
            exp16 = q16.pop_front();
            check("rand_s16", {s16_out_valid, s16_cout, s16_ovf, s16_sum}, exp16);
         end
      end
      r_valid = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
